alu8_ttl: RTL and testbench

//   8-bit add/subtract ALU for the nic8 datapath, structured as a TTL netlist.

---
 rtl/alu8_ttl.sv | 170 +++++++++++++++++
 tb/tb_alu8_ttl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu8_ttl.sv
// ---------------------------------------------------------------------------
// alu8_ttl -- 8-bit add/subtract ALU for the nic8 datapath, built as a small
// TTL-style netlist: two quad-XOR conditional inverters feed two cascaded
// 4-bit adder slices, and an octal bus driver puts the result on the data bus.
// A registered carry flag and a combinational A==0 indicator feed the
// conditional-jump logic.
//
// Ports (top):
//   clk          in   1  system clock, rising-edge
//   reset        in   1  asynchronous active-high, clears the flag registers
//   doSubtract   in   1  1: A - B (B inverted, carry-in 1); 0: A + B
//   assertBarE   in   1  active-low bus output enable and flag-load enable
//   areg         in   8  operand A
//   breg         in   8  operand B
//   dbus         out  8  tri-state data bus, driven only when assertBarE=0
//   aIsZero      out  1  combinational, 1 when areg == 0
//   flagCarry    out  1  registered carry-out of the high adder slice
//   flagOverflow out  1  registered signed overflow (ALU8_OVERFLOW_FLAG_EN only)
//
// Build option: define ALU8_OVERFLOW_FLAG_EN to add the flagOverflow output
// and its register. Without it the port does not exist.
// ---------------------------------------------------------------------------

// Quad XOR: conditionally inverts a nibble (one 74x86 package).
module alu8_ttl_xor4 (
  input  logic [3:0] a_i,
  input  logic       inv_i,
  output logic [3:0] y_o
);
  assign y_o = a_i ^ {4{inv_i}};
endmodule

// 4-bit ripple full adder slice (one 74x283 package).
module alu8_ttl_add4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign sum_o[g] = a_i[g] ^ b_i[g] ^ c[g];
    assign c[g+1]   = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
  end

  assign cout_o = c[4];
endmodule

// Octal bus driver with fixed A->B direction (one 74x245 package).
// The bus is released (high impedance) while the active-low enable is high.
module alu8_ttl_drv8 (
  input  logic [7:0] a_i,
  input  logic       oe_n_i,
  output logic [7:0] b_o
);
  assign b_o = oe_n_i ? 8'hZZ : a_i;
endmodule

module alu8_ttl (
  input  logic       clk,
  input  logic       reset,
  input  logic       doSubtract,
  input  logic       assertBarE,
  input  logic [7:0] areg,
  input  logic [7:0] breg,
  output logic [7:0] dbus,
  output logic       aIsZero,
`ifdef ALU8_OVERFLOW_FLAG_EN
  output logic       flagOverflow,
`endif
  output logic       flagCarry
);

  logic [7:0] other;
  logic [7:0] aluOut;
  logic       coutLO;
  logic       coutHI;

  logic       flag_carry_d;
  logic       flag_carry_q;

  // B conditional inversion: two's-complement subtract is A + ~B + 1,
  // the +1 coming in as the low slice carry-in.
  alu8_ttl_xor4 u_xor_lo (
    .a_i   (breg[3:0]),
    .inv_i (doSubtract),
    .y_o   (other[3:0])
  );

  alu8_ttl_xor4 u_xor_hi (
    .a_i   (breg[7:4]),
    .inv_i (doSubtract),
    .y_o   (other[7:4])
  );

  // Adder slices, carry rippled lo -> hi.
  alu8_ttl_add4 u_add_lo (
    .a_i    (areg[3:0]),
    .b_i    (other[3:0]),
    .cin_i  (doSubtract),
    .sum_o  (aluOut[3:0]),
    .cout_o (coutLO)
  );

  alu8_ttl_add4 u_add_hi (
    .a_i    (areg[7:4]),
    .b_i    (other[7:4]),
    .cin_i  (coutLO),
    .sum_o  (aluOut[7:4]),
    .cout_o (coutHI)
  );

  alu8_ttl_drv8 u_drv (
    .a_i    (aluOut),
    .oe_n_i (assertBarE),
    .b_o    (dbus)
  );

  assign aIsZero = (areg == 8'h00);

  // The flag only loads while the ALU owns the bus; otherwise it holds.
  always_comb begin
    flag_carry_d = flag_carry_q;
    if (!assertBarE) begin
      flag_carry_d = coutHI;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_carry_q <= 1'b0;
    end else begin
      flag_carry_q <= flag_carry_d;
    end
  end

  assign flagCarry = flag_carry_q;

`ifdef ALU8_OVERFLOW_FLAG_EN
  logic c_into7;
  logic flag_ovf_d;
  logic flag_ovf_q;

  // Sum bit 7 is a7 ^ b7 ^ c7, so the carry into bit 7 is recovered by
  // XORing the operand bits back out of it. Overflow is c8 ^ c7.
  assign c_into7 = areg[7] ^ other[7] ^ aluOut[7];

  always_comb begin
    flag_ovf_d = flag_ovf_q;
    if (!assertBarE) begin
      flag_ovf_d = coutHI ^ c_into7;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_ovf_q <= 1'b0;
    end else begin
      flag_ovf_q <= flag_ovf_d;
    end
  end

  assign flagOverflow = flag_ovf_q;
`endif

endmodule

// File: tb/tb_alu8_ttl.sv
module tb_alu8_ttl;

  logic       clk;
  logic       reset;
  logic       doSubtract;
  logic       assertBarE;
  logic [7:0] areg;
  logic [7:0] breg;
  wire  [7:0] dbus;
  logic       aIsZero;
  logic       flagCarry;
`ifdef ALU8_OVERFLOW_FLAG_EN
  logic       flagOverflow;
`endif

  int n_cmp;
  int n_bad;

  // Released bus floats high, so an undriven bus reads 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (dbus[g]);
  end

  alu8_ttl dut (
    .clk          (clk),
    .reset        (reset),
    .doSubtract   (doSubtract),
    .assertBarE   (assertBarE),
    .areg         (areg),
    .breg         (breg),
    .dbus         (dbus),
    .aIsZero      (aIsZero),
`ifdef ALU8_OVERFLOW_FLAG_EN
    .flagOverflow (flagOverflow),
`endif
    .flagCarry    (flagCarry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, want %02h", tag, obs, exp);
    end
  endtask

  // Drive operands just after a falling edge, let combinational paths settle.
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic bare);
    @(negedge clk);
    areg       = a;
    breg       = b;
    doSubtract = sub;
    assertBarE = bare;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    doSubtract = 1'b0;
    assertBarE = 1'b0;
    areg       = 8'hFF;
    breg       = 8'h01;

    // Reset holds the flag clear even across clock edges with a carry present.
    tick();
    chk("reset_fc", {7'd0, flagCarry}, 8'h00);
`ifdef ALU8_OVERFLOW_FLAG_EN
    chk("reset_ovf", {7'd0, flagOverflow}, 8'h00);
`endif
    @(negedge clk);
    reset = 1'b0;

    // 35 + 4A = 7F, no carry
    drive(8'h35, 8'h4A, 1'b0, 1'b0);
    chk("add_35_4a_bus", dbus, 8'h7F);
    chk("add_35_4a_az", {7'd0, aIsZero}, 8'h00);
    tick();
    chk("add_35_4a_fc", {7'd0, flagCarry}, 8'h00);

    // 0F + 01 = 10, nibble carry ripples into the high slice
    drive(8'h0F, 8'h01, 1'b0, 1'b0);
    chk("add_0f_01_bus", dbus, 8'h10);
    tick();
    chk("add_0f_01_fc", {7'd0, flagCarry}, 8'h00);

    // FF + 01 wraps to 00 with carry; A itself is not zero
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("add_ff_01_bus", dbus, 8'h00);
    chk("add_ff_01_az", {7'd0, aIsZero}, 8'h00);
    tick();
    chk("add_ff_01_fc", {7'd0, flagCarry}, 8'h01);

    // 10 - 01 = 0F, no borrow -> carry 1
    drive(8'h10, 8'h01, 1'b1, 1'b0);
    chk("sub_10_01_bus", dbus, 8'h0F);
    tick();
    chk("sub_10_01_fc", {7'd0, flagCarry}, 8'h01);

    // 01 - 02 = FF, borrow -> carry 0
    drive(8'h01, 8'h02, 1'b1, 1'b0);
    chk("sub_01_02_bus", dbus, 8'hFF);
    tick();
    chk("sub_01_02_fc", {7'd0, flagCarry}, 8'h00);

    // Bus released; 80 + 90 = 110 would set carry but load is disabled
    drive(8'h80, 8'h90, 1'b0, 1'b1);
    chk("bare_bus_z", dbus, 8'hFF);
    tick();
    chk("bare_fc_hold0", {7'd0, flagCarry}, 8'h00);

    // A == 0 detect works independent of bus enable
    drive(8'h00, 8'h55, 1'b0, 1'b1);
    chk("az_one", {7'd0, aIsZero}, 8'h01);

    // Same carry-producing sum with bus enabled loads the flag
    drive(8'h80, 8'h90, 1'b0, 1'b0);
    chk("add_80_90_bus", dbus, 8'h10);
    tick();
    chk("add_80_90_fc", {7'd0, flagCarry}, 8'h01);

    // Hold a 1 with bus released: 01 - 02 borrows but must not load
    drive(8'h01, 8'h02, 1'b1, 1'b1);
    tick();
    chk("bare_fc_hold1", {7'd0, flagCarry}, 8'h01);

    // Asynchronous reset between edges clears at once, stays clear after release
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_fc", {7'd0, flagCarry}, 8'h00);
    reset = 1'b0;
    #1;
    chk("rst_release_fc", {7'd0, flagCarry}, 8'h00);
    tick();
    chk("rst_hold_fc", {7'd0, flagCarry}, 8'h00);

    // doSubtract toggles mid-cycle: 10 - 01 would carry, 10 + 01 does not.
    drive(8'h10, 8'h01, 1'b1, 1'b0);
    chk("toggle_sub_bus", dbus, 8'h0F);
    #1;
    doSubtract = 1'b0;
    #1;
    chk("toggle_add_bus", dbus, 8'h11);
    tick();
    chk("toggle_fc", {7'd0, flagCarry}, 8'h00);

    // 7F + 01 = 80: signed overflow, no unsigned carry
    drive(8'h7F, 8'h01, 1'b0, 1'b0);
    chk("add_7f_01_bus", dbus, 8'h80);
    tick();
    chk("add_7f_01_fc", {7'd0, flagCarry}, 8'h00);
`ifdef ALU8_OVERFLOW_FLAG_EN
    chk("add_7f_01_ovf", {7'd0, flagOverflow}, 8'h01);
    // FF + 01: carry but no signed overflow
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    chk("add_ff_01_ovf", {7'd0, flagOverflow}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
